// File: rtl/cache_set_store.sv
`default_nettype none
// ============================================================================
// cache_set_store: N-way set-associative tag/data/MESI store with true-LRU
// replacement, one request in flight, and a self-initialising clear sweep.
// Revision: 1.0
// ============================================================================
module cache_set_store #(
  parameter int INDEX_BITS = 14,
  parameter int TAG_BITS   = 12,
  parameter int LINE_BITS  = 512,
  parameter int WAYS       = 8,
  localparam int WB        = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [TAG_BITS-1:0]   req_tag,
  input  logic [LINE_BITS-1:0]  req_wdata,
  input  logic [1:0]            req_fill_mesi,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [WB-1:0]         resp_way,
  output logic [1:0]            resp_mesi,
  output logic [LINE_BITS-1:0]  resp_rdata,
  output logic                  resp_wb,
  output logic [TAG_BITS-1:0]   resp_wb_tag,
  output logic                  resp_upgrade
);

  localparam int SETS = 1 << INDEX_BITS;

  localparam logic [1:0] c_sInit   = 2'd0;
  localparam logic [1:0] c_sIdle   = 2'd1;
  localparam logic [1:0] c_sLookup = 2'd2;
  localparam logic [1:0] c_sResp   = 2'd3;

  localparam logic [2:0] c_opRead  = 3'd0;
  localparam logic [2:0] c_opWrite = 3'd1;
  localparam logic [2:0] c_opFill  = 3'd2;
  localparam logic [2:0] c_opSnRd  = 3'd3;
  localparam logic [2:0] c_opSnInv = 3'd4;

  localparam logic [1:0] c_mesiI = 2'b00;
  localparam logic [1:0] c_mesiS = 2'b01;
  localparam logic [1:0] c_mesiM = 2'b11;

  localparam logic [WB-1:0] c_ageLru = WB'(WAYS - 1);

  logic [1:0]            r_state;
  logic [INDEX_BITS-1:0] r_initIdx;
  logic [2:0]            r_op;
  logic [INDEX_BITS-1:0] r_index;
  logic [TAG_BITS-1:0]   r_tag;
  logic [LINE_BITS-1:0]  r_wdata;
  logic [1:0]            r_fillMesi;
  logic [WB-1:0]         r_way;
  logic                  r_hit;

  logic [1:0]           r_mesiArr [SETS][WAYS];
  logic [WB-1:0]        r_ageArr  [SETS][WAYS];
  logic [TAG_BITS-1:0]  r_tagArr  [SETS][WAYS];
  logic [LINE_BITS-1:0] r_dataArr [SETS][WAYS];

  logic                 w_hit;
  logic [WB-1:0]        w_hitWay;
  logic                 w_invFound;
  logic [WB-1:0]        w_invWay;
  logic [WB-1:0]        w_lruWay;
  logic                 w_isFill;
  logic                 w_isSnoop;
  logic                 w_hitEff;
  logic [WB-1:0]        w_way;
  logic [1:0]           w_wayMesi;
  logic [TAG_BITS-1:0]  w_wayTag;
  logic [LINE_BITS-1:0] w_wayData;
  logic                 w_wb;
  logic                 w_touch;
  logic [WB-1:0]        w_touchAge;

  assign req_ready = (r_state == c_sIdle);

  always_comb begin
    w_hit      = 1'b0;
    w_hitWay   = '0;
    w_invFound = 1'b0;
    w_invWay   = '0;
    w_lruWay   = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!w_hit && r_mesiArr[r_index][i] != c_mesiI && r_tagArr[r_index][i] == r_tag) begin
        w_hit    = 1'b1;
        w_hitWay = WB'(i);
      end
      if (!w_invFound && r_mesiArr[r_index][i] == c_mesiI) begin
        w_invFound = 1'b1;
        w_invWay   = WB'(i);
      end
      if (r_ageArr[r_index][i] == c_ageLru) begin
        w_lruWay = WB'(i);
      end
    end
  end

  // Ops 5-7 never hit; FILL picks matching way, then first invalid, then LRU.
  assign w_isFill  = (r_op == c_opFill);
  assign w_isSnoop = (r_op == c_opSnRd) || (r_op == c_opSnInv);
  assign w_hitEff  = w_hit && (r_op <= c_opSnInv);
  assign w_way     = w_isFill ? (w_hit ? w_hitWay : (w_invFound ? w_invWay : w_lruWay)) : w_hitWay;
  assign w_wayMesi = r_mesiArr[r_index][w_way];
  assign w_wayTag  = r_tagArr[r_index][w_way];
  assign w_wayData = r_dataArr[r_index][w_way];
  assign w_wb      = (w_wayMesi == c_mesiM) && (w_isFill ? !w_hit : (w_isSnoop && w_hit));

  assign w_touch    = w_isFill || (r_hit && (r_op == c_opRead || r_op == c_opWrite));
  assign w_touchAge = r_ageArr[r_index][r_way];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_sInit;
      r_initIdx    <= '0;
      init_done    <= 1'b0;
      r_op         <= '0;
      r_index      <= '0;
      r_tag        <= '0;
      r_wdata      <= '0;
      r_fillMesi   <= '0;
      r_way        <= '0;
      r_hit        <= 1'b0;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_way     <= '0;
      resp_mesi    <= '0;
      resp_rdata   <= '0;
      resp_wb      <= 1'b0;
      resp_wb_tag  <= '0;
      resp_upgrade <= 1'b0;
    end else begin
      case (r_state)
        c_sInit: begin
          r_initIdx <= r_initIdx + 1'b1;
          if (&r_initIdx) begin
            r_state   <= c_sIdle;
            init_done <= 1'b1;
          end
        end
        c_sIdle: begin
          if (req_valid) begin
            r_op       <= req_op;
            r_index    <= req_index;
            r_tag      <= req_tag;
            r_wdata    <= req_wdata;
            r_fillMesi <= req_fill_mesi;
            r_state    <= c_sLookup;
          end
        end
        c_sLookup: begin
          r_way        <= w_way;
          r_hit        <= w_hitEff;
          resp_valid   <= 1'b1;
          resp_hit     <= w_hitEff;
          resp_way     <= w_way;
          resp_mesi    <= (w_hitEff || w_isFill) ? w_wayMesi : c_mesiI;
          resp_rdata   <= (w_hitEff || w_wb) ? w_wayData : '0;
          resp_wb      <= w_wb;
          resp_wb_tag  <= w_wayTag;
          resp_upgrade <= (r_op == c_opWrite) && w_hit && (w_wayMesi == c_mesiS);
          r_state      <= c_sResp;
        end
        c_sResp: begin
          resp_valid <= 1'b0;
          r_state    <= c_sIdle;
        end
        default: r_state <= c_sInit;
      endcase
    end
  end

  // Arrays carry no reset: the INIT sweep establishes a clean state.
  always_ff @(posedge clk) begin
    if (r_state == c_sInit) begin
      for (int i = 0; i < WAYS; i++) begin
        r_mesiArr[r_initIdx][i] <= c_mesiI;
        r_ageArr[r_initIdx][i]  <= WB'(i);
      end
    end else if (r_state == c_sResp) begin
      case (r_op)
        c_opWrite: begin
          if (r_hit) begin
            r_dataArr[r_index][r_way] <= r_wdata;
            r_mesiArr[r_index][r_way] <= c_mesiM;
          end
        end
        c_opFill: begin
          r_tagArr[r_index][r_way]  <= r_tag;
          r_dataArr[r_index][r_way] <= r_wdata;
          r_mesiArr[r_index][r_way] <= r_fillMesi;
        end
        c_opSnRd: begin
          if (r_hit) r_mesiArr[r_index][r_way] <= c_mesiS;
        end
        c_opSnInv: begin
          if (r_hit) r_mesiArr[r_index][r_way] <= c_mesiI;
        end
        default: ;
      endcase
      if (w_touch) begin
        for (int i = 0; i < WAYS; i++) begin
          if (WB'(i) == r_way) begin
            r_ageArr[r_index][i] <= '0;
          end else if (r_ageArr[r_index][i] < w_touchAge) begin
            r_ageArr[r_index][i] <= r_ageArr[r_index][i] + 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cache_set_store.md
# cache_set_store

Parametrised N-way set-associative tag/data/state store for the L2 cache simulator, with true-LRU replacement and MESI state per line. Sits between the cache controller and the shared-bus snoop logic. Executes one request at a time over a valid/ready handshake: read, write, fill-with-victim-selection, and snoop. After reset it runs a self-initialising sweep that clears every set.

## Interface
- INDEX_BITS, 14, set index width; sets = 2^INDEX_BITS
- TAG_BITS, 12, tag width
- LINE_BITS, 512, data line width
- WAYS, 8, associativity; power of two, >= 2; WB = $clog2(WAYS)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- init_done  out  1  high once the init sweep completes
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_op  in  3  0 READ, 1 WRITE, 2 FILL, 3 SNOOP_RD, 4 SNOOP_INV; 5–7 are no-op misses
- req_index  in  INDEX_BITS  set select
- req_tag  in  TAG_BITS  address tag
- req_wdata  in  LINE_BITS  line data for WRITE/FILL
- req_fill_mesi  in  2  state installed by FILL
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  tag matched a non-I way
- resp_way  out  WB  hit way, or victim way for FILL
- resp_mesi  out  2  state of that way before the op
- resp_rdata  out  LINE_BITS  hit data; writeback data when resp_wb=1
- resp_wb  out  1  dirty line must be written back
- resp_wb_tag  out  TAG_BITS  tag of the written-back line
- resp_upgrade  out  1  WRITE hit a line in S; controller must broadcast an invalidate

## Operation
- MESI encoding: I=00, S=01, E=10, M=11. A way is valid iff mesi != I.
- Per-set LRU uses WB-bit ages per way; 0 = MRU, WAYS-1 = LRU. On a touch of way w with age a, every way with age < a increments and w is set to 0. Ages form a permutation at all times.
- FSM states: INIT, IDLE, LOOKUP, RESP.
- INIT: entered on reset. Walks index 0..2^INDEX_BITS-1, one set per cycle. For each set: all mesi=I, way i age=i, tags/data don't-care. Then init_done=1 and the FSM moves to IDLE.
- IDLE: req_ready=1. A request is accepted on req_valid & req_ready. The FSM latches all req_* and moves to LOOKUP.
- LOOKUP: reads the set, compares tags, and computes the victim. Moves to RESP.
- RESP: performs the array/LRU update, drives resp_valid=1 for one cycle, then returns to IDLE.
- READ: on hit, returns data and touches LRU. On miss, resp_hit=0 and nothing changes.
- WRITE: on hit, writes req_wdata, sets mesi=M and touches LRU. resp_upgrade=1 iff prior mesi was S. On miss, nothing changes.
- FILL, victim selection in order:
  - the matching valid way if the tag is already present (no duplicates);
  - else the lowest-numbered invalid way;
  - else the way with age WAYS-1.
- FILL, effect: if the victim is M with a different tag, resp_wb=1, resp_wb_tag=victim tag, resp_rdata=victim data. Then installs tag/req_wdata/req_fill_mesi and touches LRU. resp_hit reflects the tag match.
- SNOOP_RD: M→S with resp_wb=1 and data; E→S; S stays S. LRU unchanged.
- SNOOP_INV: any→I; resp_wb=1 and data if prior state was M. LRU unchanged.
- Outputs other than resp_valid hold their last value between responses.

## Timing
- Reset values: req_ready=0, init_done=0, resp_valid=0, and all other resp_* = 0.
- Init takes exactly 2^INDEX_BITS cycles after rst_n deasserts. init_done and req_ready rise together.
- Latency: resp_valid is asserted in the 2nd cycle after the acceptance edge. Throughput is one request per 3 cycles; req_ready=0 in LOOKUP and RESP.
- A request that is present while req_ready=0 is not consumed; the requester holds it.
- No response backpressure; resp_valid is always a single-cycle pulse.
- Back-to-back requests to the same set see the prior op's update, because the update completes in RESP before IDLE.
- Asserting rst_n low mid-op immediately drops resp_valid and req_ready. The in-flight op is discarded and INIT restarts from set 0.

## Test plan
Run with WAYS=4, INDEX_BITS=4, TAG_BITS=8, LINE_BITS=32.
- Reset, then count cycles: init_done rises exactly 16 cycles after rst_n rises; READ tag 0x11 at any set → resp_hit=0.
- FILL set 3 with tags 0xA0..0xA3 (mesi E), then READ 0xA0: ways 0..3 are filled in order; the read hits way 0 with resp_mesi=E and returns the filled data.
- WRITE 0xA1 data 0xDEADBEEF, then FILL 0xB0: the write leaves 0xA1 in M. The LRU is 0xA2 (way 2), so the FILL evicts way 2 with resp_wb=0. Next FILL 0xB1 evicts 0xA3 (way 3); the FILL after that evicts 0xA0.
- FILL (S) a tag, WRITE it → resp_upgrade=1, state M. SNOOP_RD it → resp_wb=1, data correct, state S. SNOOP_INV → resp_mesi=S, resp_wb=0; a subsequent READ misses.
- FILL over an M line from a full set → resp_wb=1, resp_wb_tag=old tag, resp_rdata=old data.
- Assert rst_n during LOOKUP → no resp_valid, init restarts, all lines invalid afterward.
